clock_set_controller: RTL and testbench



---
 rtl/clock_set_controller.sv | 184 ++++++++++++++++++
 tb/tb_clock_set_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_controller.sv
// Tick generator, carry router and time-set FSM for the 7-segment clock's BCD counter chain.
// Optional ADV auto-repeat in the set states is enabled with `define CLOCK_SET_AUTO_REPEAT_EN.
module clock_set_controller #(
    parameter int unsigned TICK_DIV   = 10000000,
    parameter int unsigned HOLD_TICKS = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       btn_mode_i,
    input  logic       btn_adv_i,
    input  logic       sec_ovf_i,
    input  logic       min_ovf_i,
    output logic       tick_o,
    output logic       inc_sec_o,
    output logic       inc_min_o,
    output logic       inc_hr_o,
    output logic       clr_sec_o,
    output logic [1:0] mode_o,
    output logic       sel_hr_o,
    output logic       sel_min_o,
    output logic       blink_o
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2
    } state_e;

    localparam int unsigned CNT_W = (TICK_DIV < 2) ? 1 : $clog2(TICK_DIV);

    state_e             state_q;
    state_e             state_d;
    logic [CNT_W-1:0]   pre_cnt_q;
    logic               tick_q;
    logic               mode_q;
    logic               adv_q;
    logic               clr_q;
    logic               blink_q;
    logic               inc_hr_q;
    logic               inc_min_q;

    logic               mode_rise;
    logic               adv_rise;
    logic               pre_wrap;
    logic               exit_set;
    logic               repeat_fire;
    logic               clr_d;
    logic               blink_d;
    logic               inc_hr_d;
    logic               inc_min_d;

    assign mode_rise = btn_mode_i & ~mode_q;
    assign adv_rise  = btn_adv_i & ~adv_q;
    assign pre_wrap  = (pre_cnt_q == CNT_W'(TICK_DIV - 1));
    assign exit_set  = (state_q == SET_MIN) && mode_rise;

    // Leaving SET_MIN restarts the second from zero, so a wrap landing on that
    // same cycle is dropped to keep the first tick a full period away.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else if (exit_set) begin
            pre_cnt_q <= '0;
            tick_q    <= 1'b0;
        end else begin
            tick_q    <= pre_wrap;
            pre_cnt_q <= pre_wrap ? '0 : pre_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mode_q <= 1'b0;
            adv_q  <= 1'b0;
        end else begin
            mode_q <= btn_mode_i;
            adv_q  <= btn_adv_i;
        end
    end

`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int unsigned HOLD_W = (HOLD_TICKS < 1) ? 1 : $clog2(HOLD_TICKS + 1);

    logic [HOLD_W-1:0] hold_q;
    logic              hold_done;

    // The tick that brings the count up to HOLD_TICKS already repeats.
    assign hold_done   = (32'(hold_q) + 32'd1) >= HOLD_TICKS;
    assign repeat_fire = (state_q != RUN) && btn_adv_i && tick_q && hold_done;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hold_q <= '0;
        end else if (mode_rise || !btn_adv_i || (state_q == RUN)) begin
            hold_q <= '0;
        end else if (tick_q && (32'(hold_q) < HOLD_TICKS)) begin
            hold_q <= hold_q + 1'b1;
        end
    end
`else
    assign repeat_fire = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            clr_q     <= 1'b0;
            blink_q   <= 1'b1;
            inc_hr_q  <= 1'b0;
            inc_min_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_q     <= clr_d;
            blink_q   <= blink_d;
            inc_hr_q  <= inc_hr_d;
            inc_min_q <= inc_min_d;
        end
    end

    // A MODE rise always takes priority, so an ADV rise in the same cycle is lost.
    always_comb begin
        state_d   = state_q;
        clr_d     = 1'b0;
        blink_d   = blink_q;
        inc_hr_d  = 1'b0;
        inc_min_d = 1'b0;
        case (state_q)
            RUN: begin
                blink_d = 1'b1;
                if (mode_rise) begin
                    state_d = SET_HR;
                end
            end
            SET_HR: begin
                if (mode_rise) begin
                    state_d = SET_MIN;
                    blink_d = 1'b1;
                end else begin
                    if (tick_q) begin
                        blink_d = ~blink_q;
                    end
                    inc_hr_d = adv_rise | repeat_fire;
                end
            end
            SET_MIN: begin
                if (mode_rise) begin
                    state_d = RUN;
                    clr_d   = 1'b1;
                    blink_d = 1'b1;
                end else begin
                    if (tick_q) begin
                        blink_d = ~blink_q;
                    end
                    inc_min_d = adv_rise | repeat_fire;
                end
            end
            default: begin
                state_d = RUN;
                blink_d = 1'b1;
            end
        endcase
    end

    // Carries pass straight through in RUN; while setting, only the set pulses reach the chain.
    always_comb begin
        tick_o    = tick_q;
        inc_sec_o = 1'b0;
        inc_min_o = inc_min_q;
        inc_hr_o  = inc_hr_q;
        if (state_q == RUN) begin
            inc_sec_o = tick_q;
            inc_min_o = sec_ovf_i;
            inc_hr_o  = min_ovf_i;
        end
        clr_sec_o = clr_q;
        mode_o    = state_q;
        sel_hr_o  = (state_q == SET_HR);
        sel_min_o = (state_q == SET_MIN);
        blink_o   = blink_q | (state_q == RUN);
    end

endmodule

// File: tb/tb_clock_set_controller.sv
// Self-checking bench for clock_set_controller: cycle vector table through a scoreboard queue,
// then a long ADV hold in SET_MIN whose pulse count depends on CLOCK_SET_AUTO_REPEAT_EN.
module tb_clock_set_controller;

    localparam int unsigned TICK_DIV   = 4;
    localparam int unsigned HOLD_TICKS = 2;
`ifdef CLOCK_SET_AUTO_REPEAT_EN
    localparam int EXP_HOLD_PULSES = 6;
`else
    localparam int EXP_HOLD_PULSES = 1;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_mode;
    logic       btn_adv;
    logic       sec_ovf;
    logic       min_ovf;
    logic       tick_o;
    logic       inc_sec_o;
    logic       inc_min_o;
    logic       inc_hr_o;
    logic       clr_sec_o;
    logic [1:0] mode_o;
    logic       sel_hr_o;
    logic       sel_min_o;
    logic       blink_o;

    typedef struct {
        logic       rst_n;
        logic       mode;
        logic       adv;
        logic       sec_ovf;
        logic       min_ovf;
        logic [9:0] exp;
    } vec_t;

    vec_t       table_q[$];
    logic [9:0] expected_q[$];
    int         checks   = 0;
    int         failures = 0;

    clock_set_controller #(
        .TICK_DIV  (TICK_DIV),
        .HOLD_TICKS(HOLD_TICKS)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .btn_mode_i(btn_mode),
        .btn_adv_i (btn_adv),
        .sec_ovf_i (sec_ovf),
        .min_ovf_i (min_ovf),
        .tick_o    (tick_o),
        .inc_sec_o (inc_sec_o),
        .inc_min_o (inc_min_o),
        .inc_hr_o  (inc_hr_o),
        .clr_sec_o (clr_sec_o),
        .mode_o    (mode_o),
        .sel_hr_o  (sel_hr_o),
        .sel_min_o (sel_min_o),
        .blink_o   (blink_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [9:0] packOut(input logic t, input logic is, input logic im,
                                           input logic ih, input logic cl,
                                           input logic [1:0] md, input logic bl);
        return {t, is, im, ih, cl, md, (md == 2'd1), (md == 2'd2), bl};
    endfunction

    task automatic addRow(input logic r, input logic m, input logic a, input logic so,
                          input logic mo, input logic t, input logic is, input logic im,
                          input logic ih, input logic cl, input logic [1:0] md, input logic bl);
        vec_t v;
        v.rst_n   = r;
        v.mode    = m;
        v.adv     = a;
        v.sec_ovf = so;
        v.min_ovf = mo;
        v.exp     = packOut(t, is, im, ih, cl, md, bl);
        table_q.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk);
        #1;
        rst_n    = v.rst_n;
        btn_mode = v.mode;
        btn_adv  = v.adv;
        sec_ovf  = v.sec_ovf;
        min_ovf  = v.min_ovf;
        expected_q.push_back(v.exp);
    endtask

    task automatic checkOutput(input string name);
        logic [9:0] e;
        logic [9:0] act;
        @(negedge clk);
        checks++;
        act = {tick_o, inc_sec_o, inc_min_o, inc_hr_o, clr_sec_o, mode_o,
               sel_hr_o, sel_min_o, blink_o};
        if (expected_q.size() == 0) begin
            failures++;
            $display("[TB] FAIL %s: scoreboard empty, actual=%b", name, act);
        end else begin
            e = expected_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("[TB] FAIL %s: actual {tick,isec,imin,ihr,clr,mode,shr,smin,blink}=%b required=%b",
                         name, act, e);
            end
        end
    endtask

    task automatic driveCycle(input logic r, input logic m, input logic a,
                              input logic so, input logic mo);
        @(posedge clk);
        #1;
        rst_n    = r;
        btn_mode = m;
        btn_adv  = a;
        sec_ovf  = so;
        min_ovf  = mo;
        @(negedge clk);
    endtask

    task automatic checkValue(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d required=%0d", name, act, exp);
        end
    endtask

    initial begin
        int guard;
        int ticks;
        int pulses;
        int side_seen;

        rst_n    = 1'b0;
        btn_mode = 1'b0;
        btn_adv  = 1'b0;
        sec_ovf  = 1'b0;
        min_ovf  = 1'b0;
        driveCycle(0, 0, 0, 0, 0);
        driveCycle(0, 0, 0, 0, 0);

        //     rst m a so mo | tick isec imin ihr clr mode blink
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);  // c0 reset state
        addRow(1, 0, 0, 1, 0,   0, 0, 1, 0, 0, 2'd0, 1);  // c1 sec carry
        addRow(1, 0, 0, 0, 1,   0, 0, 0, 1, 0, 2'd0, 1);  // c2 min carry
        addRow(1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);  // c3 ADV ignored in RUN
        addRow(1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 2'd0, 1);  // c4 first tick
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);
        addRow(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);  // c6 MODE rise
        addRow(1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 2'd1, 1);  // c7 SET_HR, ADV rise 1
        addRow(1, 0, 0, 1, 0,   1, 0, 0, 1, 0, 2'd1, 1);  // c8 pulse 1, carry ignored
        addRow(1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2'd1, 0);  // c9 ADV rise 2
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 1, 0, 2'd1, 0);
        addRow(1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2'd1, 0);  // c11 ADV rise 3
        addRow(1, 0, 0, 0, 0,   1, 0, 0, 1, 0, 2'd1, 0);
        addRow(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 2'd1, 1);  // c13 min carry ignored
        addRow(1, 1, 1, 0, 0,   0, 0, 0, 0, 0, 2'd1, 1);  // c14 MODE+ADV together
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd2, 1);
        addRow(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd2, 1);
        addRow(1, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2'd2, 0);  // c17 ADV rise in SET_MIN
        addRow(1, 0, 0, 0, 0,   0, 0, 1, 0, 0, 2'd2, 0);
        addRow(1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 2'd2, 0);
        addRow(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd2, 0);
        addRow(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2'd2, 1);  // c21 leave SET_MIN
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 1, 2'd0, 1);  // c22 clr_sec pulse
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);
        addRow(1, 0, 0, 0, 0,   1, 1, 0, 0, 0, 2'd0, 1);  // c26 tick 4 after clr
        addRow(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd1, 1);
        addRow(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2'd1, 1);
        addRow(1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd2, 1);
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd2, 0);
        addRow(0, 1, 0, 0, 0,   0, 0, 0, 0, 0, 2'd2, 0);  // c32 reset mid-set
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);  // c33 aborted, no clr
        addRow(1, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd0, 1);

        for (int i = 0; i < table_q.size(); i++) begin
            applyStimulus(table_q[i]);
            checkOutput($sformatf("vec_c%0d", i));
        end

        driveCycle(1, 1, 0, 0, 0);
        driveCycle(1, 0, 0, 0, 0);
        driveCycle(1, 1, 0, 0, 0);
        driveCycle(1, 0, 0, 0, 0);
        checkValue("enter_set_min", int'(mode_o), 2);

        guard = 0;
        while (tick_o !== 1'b1 && guard < 3 * TICK_DIV) begin
            driveCycle(1, 0, 0, 0, 0);
            guard++;
        end
        checkValue("tick_wait", int'(tick_o), 1);

        pulses    = 0;
        ticks     = 0;
        side_seen = 0;
        driveCycle(1, 0, 1, 0, 0);
        checkValue("adv_not_same_cycle", int'(inc_min_o), 0);
        driveCycle(1, 0, 1, 0, 0);
        checkValue("adv_edge_pulse", int'(inc_min_o), 1);
        if (inc_min_o === 1'b1) pulses++;

        guard = 0;
        while (ticks < 6 && guard < 10 * TICK_DIV) begin
            driveCycle(1, 0, 1, 0, 0);
            if (tick_o === 1'b1) ticks++;
            if (inc_min_o === 1'b1) pulses++;
            if (inc_hr_o !== 1'b0 || inc_sec_o !== 1'b0) side_seen++;
            guard++;
        end
        checkValue("hold_ticks", ticks, 6);

        repeat (3) begin
            driveCycle(1, 0, 0, 0, 0);
            if (inc_min_o === 1'b1) pulses++;
            if (inc_hr_o !== 1'b0 || inc_sec_o !== 1'b0) side_seen++;
        end
        checkValue("hold_pulses", pulses, EXP_HOLD_PULSES);
        checkValue("hold_no_other_inc", side_seen, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
